// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: fetches one 16-bit word per step, decodes JMP/JZ/HALT and drives the PC controls.
// Optional fetch watchdog enabled with `define FETCH_TIMEOUT_EN (TIMEOUT cycles without mem_rdy -> fault).
module fetch_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_pc_in,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic        i_mem_rdy,
    input  logic [15:0] i_mem_data,
    input  logic        i_zero_flag,
    output logic        o_en_in,
    output logic [1:0]  o_pc_ctrl,
    output logic [7:0]  o_offset_addr,
    output logic [15:0] o_ir_out,
    output logic        o_ir_valid,
    input  logic        i_ir_ack,
    output logic        o_halted,
    output logic        o_fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b11;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT must be in 1..255");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;
    logic [7:0]  r_offset;
    logic        r_halted;
    logic        w_en_in;
    logic [1:0]  w_pc_ctrl;
    logic        w_fault;

    logic [4:0]  w_opcode;
    logic        w_is_jmp;
    logic        w_is_jz;
    logic        w_is_halt;
    logic        w_take;

    assign w_opcode  = r_ir[15:11];
    assign w_is_jmp  = (w_opcode == 5'b11000);
    assign w_is_jz   = (w_opcode == 5'b11001);
    assign w_is_halt = (w_opcode == 5'b00001);
    assign w_take    = w_is_jmp | (w_is_jz & i_zero_flag);

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
    logic [7:0] r_cnt;
    logic       r_fetch_err;

    // mem_rdy arriving in the same cycle as the limit still captures normally
    assign w_fault     = (r_state == S_FETCH) && !i_mem_rdy && (r_cnt == LP_TIMEOUT);
    assign o_fetch_err = r_fetch_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 8'h00;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state != S_FETCH) begin
                r_cnt <= 8'h00;
            end else if (!i_mem_rdy) begin
                r_cnt <= r_cnt + 8'h01;
            end
            if (w_fault) begin
                r_fetch_err <= 1'b1;
            end
        end
    end
`else
    assign w_fault     = 1'b0;
    assign o_fetch_err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_en_in      = 1'b0;
        w_pc_ctrl    = PC_HOLD;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (i_mem_rdy)    w_state_next = S_DECODE;
                else if (w_fault) w_state_next = S_HALT;
            end
            S_DECODE: begin
                if (w_is_halt) begin
                    w_state_next = S_HALT;
                end else if (w_take) begin
                    w_en_in      = 1'b1;
                    w_pc_ctrl    = PC_LOAD;
                    w_state_next = S_FETCH;
                end else begin
                    w_en_in      = 1'b1;
                    w_pc_ctrl    = PC_INC;
                    w_state_next = w_is_jz ? S_FETCH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_ir_ack) w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ir     <= 16'h0000;
            r_offset <= 8'h00;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && i_mem_rdy) begin
                r_ir <= i_mem_data;
            end
            if (r_state == S_DECODE && !w_is_halt && w_take) begin
                r_offset <= r_ir[7:0];
            end
            if (w_state_next == S_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

    // The load target is visible in the same cycle as the load strobe, then held
    assign o_offset_addr = (w_pc_ctrl == PC_LOAD) ? r_ir[7:0] : r_offset;
    assign o_mem_addr    = i_pc_in;
    assign o_mem_rd      = (r_state == S_FETCH);
    assign o_en_in       = w_en_in;
    assign o_pc_ctrl     = w_pc_ctrl;
    assign o_ir_out      = r_ir;
    assign o_ir_valid    = (r_state == S_ISSUE);
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected PC updates / issued words / halts are queued by the
// stimulus and popped by a monitor whenever the DUT strobes en_in, completes an issue, or halts.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] pc_in;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_rdy;
    logic [15:0] mem_data;
    logic        zero_flag;
    logic        en_in;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ack;
    logic        halted;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_pc_in      (pc_in),
        .o_mem_addr   (mem_addr),
        .o_mem_rd     (mem_rd),
        .i_mem_rdy    (mem_rdy),
        .i_mem_data   (mem_data),
        .i_zero_flag  (zero_flag),
        .o_en_in      (en_in),
        .o_pc_ctrl    (pc_ctrl),
        .o_offset_addr(offset_addr),
        .o_ir_out     (ir_out),
        .o_ir_valid   (ir_valid),
        .i_ir_ack     (ir_ack),
        .o_halted     (halted),
        .o_fetch_err  (fetch_err)
    );

    typedef enum int {EV_PC, EV_ISSUE, EV_HALT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [1:0]  ctrl;
        logic [7:0]  offs;
        logic [15:0] ir;
    } ev_t;

    ev_t q_exp[$];
    int  n_cmp = 0;
    int  n_err = 0;
    logic halted_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [1:0] c, input logic [7:0] o, input logic [15:0] w);
        ev_t e;
        e.kind = k; e.ctrl = c; e.offs = o; e.ir = w;
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one line per observed transaction
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (en_in) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_pc_update", 32'(pc_ctrl), 32'hFFFF);
                end else begin
                    e = q_exp.pop_front();
                    $display("[%0t] pc update ctrl=%b offs=%02h", $time, pc_ctrl, offset_addr);
                    chk("pc_event_kind", 32'(EV_PC), 32'(e.kind));
                    chk("pc_ctrl", 32'(pc_ctrl), 32'(e.ctrl));
                    if (e.ctrl == 2'b11) chk("offset_addr", 32'(offset_addr), 32'(e.offs));
                end
            end
            if (ir_valid && ir_ack) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_issue", 32'(ir_out), 32'hFFFF_FFFF);
                end else begin
                    e = q_exp.pop_front();
                    $display("[%0t] issue ir=%04h", $time, ir_out);
                    chk("issue_event_kind", 32'(EV_ISSUE), 32'(e.kind));
                    chk("ir_out", 32'(ir_out), 32'(e.ir));
                end
            end
            if (halted && !halted_d) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_halt", 32'(halted), 32'h0);
                end else begin
                    e = q_exp.pop_front();
                    $display("[%0t] halt fetch_err=%b", $time, fetch_err);
                    chk("halt_event_kind", 32'(EV_HALT), 32'(e.kind));
                end
            end
        end
        halted_d = halted;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pc_in = 16'h0042; mem_rdy = 1'b0;
        mem_data = 16'h0000; zero_flag = 1'b0; ir_ack = 1'b0;
        #2;
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_en_in", 32'(en_in), 32'h0);
        chk("rst_pc_ctrl", 32'(pc_ctrl), 32'h0);
        chk("rst_ir_out", 32'(ir_out), 32'h0);
        chk("rst_offset", 32'(offset_addr), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'h0);
        chk("mem_addr_passthru", 32'(mem_addr), 32'h0042);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_fetch", 32'(mem_rd), 32'h0);

        // 1: plain instruction, zero-wait memory, immediate ack
        push(EV_PC, 2'b01, 8'h00, 16'h0);
        push(EV_ISSUE, 2'b00, 8'h00, 16'h1234);
        mem_rdy = 1'b1; mem_data = 16'h1234; ir_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_fetch", 32'(mem_rd), 32'h1);
        tick();
        chk("t1_decode_no_rd", 32'(mem_rd), 32'h0);
        tick();
        chk("t1_issue_valid", 32'(ir_valid), 32'h1);
        chk("t1_issue_no_rd", 32'(mem_rd), 32'h0);
        tick();
        chk("t1_refetch_3cyc", 32'(mem_rd), 32'h1);
        chk("t1_valid_one_cycle", 32'(ir_valid), 32'h0);

        // 2: JMP 0x5A
        push(EV_PC, 2'b11, 8'h5A, 16'h0);
        mem_data = 16'hC05A;
        tick();
        chk("t2_no_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("t2_next_fetch", 32'(mem_rd), 32'h1);
        chk("t2_offset_held", 32'(offset_addr), 32'h5A);

        // 3: JZ not taken, then taken
        push(EV_PC, 2'b01, 8'h00, 16'h0);
        mem_data = 16'hC833; zero_flag = 1'b0;
        tick(); tick();
        chk("t3_nt_fetch", 32'(mem_rd), 32'h1);
        chk("t3_nt_offset_held", 32'(offset_addr), 32'h5A);
        push(EV_PC, 2'b11, 8'h33, 16'h0);
        zero_flag = 1'b1;
        tick(); tick();
        chk("t3_tk_fetch", 32'(mem_rd), 32'h1);
        chk("t3_tk_offset_held", 32'(offset_addr), 32'h33);
        zero_flag = 1'b0;

        // 5: execute stage stalls for 5 cycles
        push(EV_PC, 2'b01, 8'h00, 16'h0);
        push(EV_ISSUE, 2'b00, 8'h00, 16'h4321);
        mem_data = 16'h4321; ir_ack = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid_held", 32'(ir_valid), 32'h1);
            chk("t5_ir_stable", 32'(ir_out), 32'h4321);
            chk("t5_no_rd", 32'(mem_rd), 32'h0);
            chk("t5_no_en", 32'(en_in), 32'h0);
            tick();
        end
        ir_ack = 1'b1;
        tick();
        chk("t5_fetch_after_ack", 32'(mem_rd), 32'h1);

        // 4: HALT
        push(EV_HALT, 2'b00, 8'h00, 16'h0);
        mem_data = 16'h0800;
        tick();
        chk("t4_decode_no_en", 32'(en_in), 32'h0);
        tick();
        chk("t4_halted", 32'(halted), 32'h1);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_rd", 32'(mem_rd), 32'h0);
            chk("t4_no_valid", 32'(ir_valid), 32'h0);
            tick();
        end
        start = 1'b0;
        chk("t4_still_halted", 32'(halted), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_clears_halt", 32'(halted), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6: memory never ready
        mem_rdy = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        push(EV_HALT, 2'b00, 8'h00, 16'h0);
        begin
            int n_rd = 0;
            for (int i = 0; i < 40; i++) begin
                if (mem_rd) n_rd++;
                tick();
            end
            chk("t6_fetch_cycles", 32'(n_rd), 32'd16);
        end
        chk("t6_fetch_err", 32'(fetch_err), 32'h1);
        chk("t6_halted", 32'(halted), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clears_err", 32'(fetch_err), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
`else
        for (int i = 0; i < 100; i++) tick();
        chk("t6_still_fetch", 32'(mem_rd), 32'h1);
        chk("t6_no_err", 32'(fetch_err), 32'h0);
        chk("t6_not_halted", 32'(halted), 32'h0);
`endif
        chk("t6_in_fetch", 32'(mem_rd), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rd_drop", 32'(mem_rd), 32'h0);
        chk("t6_async_en_drop", 32'(en_in), 32'h0);
        chk("t6_async_valid_drop", 32'(ir_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        chk("scoreboard_drained", 32'(q_exp.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
